// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter: the CPU has priority, and a bounded-wait counter force-grants the peripheral.
// Optional build macro DMEM_ARB_WPROT_EN blocks peripheral writes below PER_WR_BASE and pulses per_err instead.
module dmem_arbiter #(
    parameter int unsigned MAX_WAIT    = 4,
    parameter logic [31:0] PER_WR_BASE = 32'h0000_0800
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_wren,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_stall,
    output logic        cpu_rvalid,
    output logic [31:0] cpu_rdata,
    input  logic        per_req,
    input  logic        per_wren,
    input  logic [31:0] per_addr,
    input  logic [31:0] per_wdata,
    output logic        per_gnt,
    output logic        per_rvalid,
    output logic [31:0] per_rdata,
    output logic        per_err,
    output logic [31:0] address_dmem,
    output logic [31:0] data,
    output logic        wren,
    input  logic [31:0] q_dmem
);

    typedef enum logic [1:0] {
        RD_NONE = 2'd0,
        RD_CPU  = 2'd1,
        RD_PER  = 2'd2
    } rd_state_e;

    localparam logic [3:0] MAX_CNT = 4'(MAX_WAIT);

    rd_state_e  rd_state, rd_next;
    logic [3:0] wait_cnt, wait_next;
    logic       forced, cpu_gnt, wr_block;

    // The peripheral wins only after MAX_WAIT consecutive denied cycles.
    assign forced = per_req && (wait_cnt == MAX_CNT);

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        cpu_gnt = 1'b0;
        per_gnt = 1'b0;
        if (reset) begin
            cpu_gnt = cpu_req && !forced;
            per_gnt = per_req && (!cpu_req || forced);
        end
    end

`ifdef DMEM_ARB_WPROT_EN
    assign wr_block = per_gnt && per_wren && (per_addr < PER_WR_BASE);
`else
    logic unused_wr_base;
    assign unused_wr_base = ^PER_WR_BASE;
    assign wr_block       = 1'b0;
`endif

    assign cpu_stall = reset && cpu_req && !cpu_gnt;
    assign per_err   = wr_block;

    // A blocked peripheral write still retires (per_gnt high) but never reaches memory.
    always_comb begin
        address_dmem = '0;
        data         = '0;
        wren         = 1'b0;
        if (reset) begin
            address_dmem = cpu_addr;
            if (cpu_gnt) begin
                data = cpu_wdata;
                wren = cpu_wren;
            end else if (per_gnt) begin
                address_dmem = per_addr;
                if (!wr_block) begin
                    data = per_wdata;
                    wren = per_wren;
                end
            end
        end
    end

    always_comb begin
        wait_next = 4'd0;
        if (per_req && !per_gnt)
            wait_next = (wait_cnt == MAX_CNT) ? wait_cnt : wait_cnt + 4'd1;
    end

    always_comb begin
        rd_next    = RD_NONE;
        cpu_rvalid = 1'b0;
        cpu_rdata  = '0;
        per_rvalid = 1'b0;
        per_rdata  = '0;
        if (cpu_gnt && !cpu_wren)
            rd_next = RD_CPU;
        else if (per_gnt && !per_wren)
            rd_next = RD_PER;
        case (rd_state)
            RD_CPU: begin
                cpu_rvalid = 1'b1;
                cpu_rdata  = q_dmem;
            end
            RD_PER: begin
                per_rvalid = 1'b1;
                per_rdata  = q_dmem;
            end
            default: ;
        endcase
    end

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset) begin
            rd_state <= RD_NONE;
            wait_cnt <= 4'd0;
        end else begin
            rd_state <= rd_next;
            wait_cnt <= wait_next;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized traffic against a behavioural model.
module tb_dmem_arbiter;

    localparam int          MAX_WAIT    = 4;
    localparam logic [31:0] PER_WR_BASE = 32'h0000_0800;

    logic        clock, reset;
    logic        cpu_req, cpu_wren, cpu_stall, cpu_rvalid;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        per_req, per_wren, per_gnt, per_rvalid, per_err;
    logic [31:0] per_addr, per_wdata, per_rdata;
    logic [31:0] address_dmem, data, q_dmem;
    logic        wren;

    int n_checks = 0;
    int n_fail   = 0;

    dmem_arbiter #(.MAX_WAIT(MAX_WAIT), .PER_WR_BASE(PER_WR_BASE)) dut (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_wren(cpu_wren), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .per_req(per_req), .per_wren(per_wren), .per_addr(per_addr), .per_wdata(per_wdata),
        .per_gnt(per_gnt), .per_rvalid(per_rvalid), .per_rdata(per_rdata), .per_err(per_err),
        .address_dmem(address_dmem), .data(data), .wren(wren), .q_dmem(q_dmem)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory with one-cycle read latency.
    logic [31:0] mem [0:1023];
    always @(posedge clock) begin
        if (wren) mem[address_dmem[11:2]] <= data;
        q_dmem <= mem[address_dmem[11:2]];
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_cpu(input logic req, input logic wr, input logic [31:0] a, input logic [31:0] d);
        cpu_req = req; cpu_wren = wr; cpu_addr = a; cpu_wdata = d;
    endtask

    task automatic set_per(input logic req, input logic wr, input logic [31:0] a, input logic [31:0] d);
        per_req = req; per_wren = wr; per_addr = a; per_wdata = d;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
        set_per(1'b0, 1'b0, 32'h0, 32'h0);
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        set_cpu(1'b1, 1'b1, 32'h44, 32'h1111);
        set_per(1'b1, 1'b1, 32'h48, 32'h2222);
        settle();
        n_checks++;
        if ({wren, per_gnt, cpu_stall, per_err, address_dmem, data} !== 68'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got wren=%b gnt=%b stall=%b err=%b addr=%h data=%h want all 0",
                     wren, per_gnt, cpu_stall, per_err, address_dmem, data);
        end
        tick();
        tick();
        n_checks++;
        if ({cpu_rvalid, per_rvalid, cpu_rdata, per_rdata} !== 66'h0) begin
            n_fail++;
            $display("FAIL reset_returns: got crv=%b prv=%b crd=%h prd=%h want all 0",
                     cpu_rvalid, per_rvalid, cpu_rdata, per_rdata);
        end
        set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
        set_per(1'b0, 1'b0, 32'h0, 32'h0);
        reset = 1'b1;
        tick();
    endtask

    task automatic test_cpu_load();
        set_cpu(1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
        settle();
        n_checks++;
        if ({address_dmem, data, wren, cpu_stall} !== {32'h10, 32'hDEADBEEF, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL cpu_store: got addr=%h data=%h wren=%b stall=%b want 10/deadbeef/1/0",
                     address_dmem, data, wren, cpu_stall);
        end
        tick();
        set_cpu(1'b1, 1'b0, 32'h10, 32'h0);
        settle();
        n_checks++;
        if (cpu_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL store_no_rvalid: got cpu_rvalid=%b want 0", cpu_rvalid);
        end
        n_checks++;
        if ({address_dmem, wren, cpu_stall} !== {32'h10, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL cpu_load_issue: got addr=%h wren=%b stall=%b want 10/0/0", address_dmem, wren, cpu_stall);
        end
        tick();
        set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
        settle();
        n_checks++;
        if ({cpu_rvalid, cpu_rdata, per_rvalid} !== {1'b1, 32'hDEADBEEF, 1'b0}) begin
            n_fail++;
            $display("FAIL cpu_load_return: got rvalid=%b rdata=%h prv=%b want 1/deadbeef/0",
                     cpu_rvalid, cpu_rdata, per_rvalid);
        end
        tick();
    endtask

    task automatic test_contention();
        for (int c = 0; c < 6; c++) begin
            set_cpu(1'b1, 1'b1, 32'h40 + 32'(c) * 32'd4, 32'(c));
            set_per(1'b1, 1'b1, 32'h50, 32'h55);
            settle();
            n_checks++;
            if ({per_gnt, cpu_stall} !== {c == 4, c == 4}) begin
                n_fail++;
                $display("FAIL contention_c%0d: got per_gnt=%b stall=%b want %b/%b", c, per_gnt, cpu_stall, c == 4, c == 4);
            end
            n_checks++;
            if (address_dmem !== ((c == 4) ? 32'h50 : 32'h40 + 32'(c) * 32'd4)) begin
                n_fail++;
                $display("FAIL contention_addr_c%0d: got %h", c, address_dmem);
            end
            tick();
        end
        idle();
    endtask

    task automatic test_alternating();
        set_cpu(1'b1, 1'b1, 32'h20, 32'hA);
        tick();
        set_cpu(1'b1, 1'b1, 32'h30, 32'hB);
        tick();
        for (int c = 0; c < 5; c++) begin
            set_cpu(1'b1, 1'b0, 32'h30, 32'h0);
            set_per(1'b1, 1'b0, 32'h20, 32'h0);
            settle();
            n_checks++;
            if ({per_gnt, cpu_stall} !== {c == 4, c == 4}) begin
                n_fail++;
                $display("FAIL alt_grant_c%0d: got per_gnt=%b stall=%b", c, per_gnt, cpu_stall);
            end
            tick();
        end
        set_per(1'b0, 1'b0, 32'h0, 32'h0);
        settle();
        n_checks++;
        if ({per_rvalid, per_rdata, cpu_rvalid, cpu_rdata} !== {1'b1, 32'hA, 1'b0, 32'h0}) begin
            n_fail++;
            $display("FAIL alt_per_return: got prv=%b prd=%h crv=%b crd=%h want 1/a/0/0",
                     per_rvalid, per_rdata, cpu_rvalid, cpu_rdata);
        end
        tick();
        set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
        settle();
        n_checks++;
        if ({cpu_rvalid, cpu_rdata, per_rvalid, per_rdata} !== {1'b1, 32'hB, 1'b0, 32'h0}) begin
            n_fail++;
            $display("FAIL alt_cpu_return: got crv=%b crd=%h prv=%b prd=%h want 1/b/0/0",
                     cpu_rvalid, cpu_rdata, per_rvalid, per_rdata);
        end
        tick();
    endtask

    task automatic test_abandon();
        for (int c = 0; c < 6; c++) begin
            set_cpu(1'b1, 1'(c % 2), 32'h60 + 32'(c) * 32'd4, 32'h100 + 32'(c));
            set_per(c < 2, 1'b1, 32'h70, 32'h77);
            settle();
            n_checks++;
            if ({per_gnt, wren, address_dmem} !== {1'b0, 1'(c % 2), 32'h60 + 32'(c) * 32'd4}) begin
                n_fail++;
                $display("FAIL abandon_c%0d: got per_gnt=%b wren=%b addr=%h", c, per_gnt, wren, address_dmem);
            end
            tick();
        end
        for (int c = 0; c < 5; c++) begin
            set_cpu(1'b1, 1'b1, 32'h80, 32'h0);
            set_per(1'b1, 1'b1, 32'h84, 32'h0);
            settle();
            n_checks++;
            if (per_gnt !== (c == 4)) begin
                n_fail++;
                $display("FAIL abandon_recount_c%0d: got per_gnt=%b want %b", c, per_gnt, c == 4);
            end
            tick();
        end
        idle();
    endtask

    task automatic test_reset_mid_read();
        set_cpu(1'b1, 1'b0, 32'h10, 32'h0);
        set_per(1'b1, 1'b0, 32'h24, 32'h0);
        settle();
        n_checks++;
        if ({cpu_stall, per_gnt} !== 2'b00) begin
            n_fail++;
            $display("FAIL midreset_issue: got stall=%b per_gnt=%b want 0/0", cpu_stall, per_gnt);
        end
        tick();
        reset = 1'b0;
        settle();
        n_checks++;
        if ({wren, per_gnt, cpu_stall, address_dmem, data} !== 67'h0) begin
            n_fail++;
            $display("FAIL midreset_forced0: got wren=%b gnt=%b stall=%b addr=%h data=%h",
                     wren, per_gnt, cpu_stall, address_dmem, data);
        end
        tick();
        reset = 1'b1;
        settle();
        n_checks++;
        if ({cpu_rvalid, per_rvalid} !== 2'b00) begin
            n_fail++;
            $display("FAIL midreset_discard: got crv=%b prv=%b want 0/0", cpu_rvalid, per_rvalid);
        end
        for (int c = 0; c < 5; c++) begin
            settle();
            n_checks++;
            if (per_gnt !== (c == 4)) begin
                n_fail++;
                $display("FAIL midreset_wait_c%0d: got per_gnt=%b want %b", c, per_gnt, c == 4);
            end
            if (c == 1) begin
                n_checks++;
                if ({cpu_rvalid, cpu_rdata} !== {1'b1, 32'hDEADBEEF}) begin
                    n_fail++;
                    $display("FAIL midreset_reload: got crv=%b crd=%h want 1/deadbeef", cpu_rvalid, cpu_rdata);
                end
            end
            tick();
        end
        idle();
    endtask

    task automatic test_wprot();
        logic blocked;
`ifdef DMEM_ARB_WPROT_EN
        blocked = 1'b1;
`else
        blocked = 1'b0;
`endif
        set_cpu(1'b1, 1'b1, 32'h100, 32'hCAFE);
        tick();
        set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
        set_per(1'b1, 1'b1, 32'h100, 32'h1234);
        settle();
        n_checks++;
        if ({per_gnt, per_err, wren, data} !== {1'b1, blocked, !blocked, blocked ? 32'h0 : 32'h1234}) begin
            n_fail++;
            $display("FAIL wprot_low: got gnt=%b err=%b wren=%b data=%h", per_gnt, per_err, wren, data);
        end
        tick();
        set_per(1'b1, 1'b1, 32'h900, 32'h5678);
        settle();
        n_checks++;
        if ({per_gnt, per_err, wren, data, address_dmem} !== {1'b1, 1'b0, 1'b1, 32'h5678, 32'h900}) begin
            n_fail++;
            $display("FAIL wprot_high: got gnt=%b err=%b wren=%b data=%h addr=%h",
                     per_gnt, per_err, wren, data, address_dmem);
        end
        tick();
        set_per(1'b1, 1'b0, 32'h100, 32'h0);
        settle();
        n_checks++;
        if (per_err !== 1'b0) begin
            n_fail++;
            $display("FAIL wprot_read_err: got per_err=%b want 0", per_err);
        end
        tick();
        set_per(1'b0, 1'b0, 32'h0, 32'h0);
        settle();
        n_checks++;
        if ({per_rvalid, per_rdata} !== {1'b1, blocked ? 32'hCAFE : 32'h1234}) begin
            n_fail++;
            $display("FAIL wprot_readback: got prv=%b prd=%h", per_rvalid, per_rdata);
        end
        tick();
    endtask

    function automatic logic [31:0] addr_of(input int i);
        return ((i >= 16) ? 32'h800 : 32'h0) + 32'(i % 16) * 32'd4;
    endfunction

    function automatic int idx_of(input logic [31:0] a);
        return (a[11] ? 16 : 0) + int'(a[5:2]);
    endfunction

    // Behavioural reference: shadow memory, denied-cycle count, and the one-deep pending read return.
    task automatic test_random();
        logic [31:0] ref_mem [0:31];
        int          denied;
        int          ret_owner;     // 0 none, 1 cpu, 2 peripheral
        logic [31:0] ret_data;
        logic        per_pend;
        logic        per_turn, cpu_turn, blocked;
        logic [31:0] e_addr, e_data;
        logic        e_wren;
        logic [31:0] v;

        for (int i = 0; i < 32; i++) begin
            v = $urandom;
            ref_mem[i] = v;
            set_cpu(1'b1, 1'b1, addr_of(i), v);
            tick();
        end
        idle();
        denied = 0; ret_owner = 0; ret_data = '0; per_pend = 1'b0;

        for (int cyc = 0; cyc < 600; cyc++) begin
            set_cpu($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), addr_of(int'($urandom_range(0, 31))), $urandom);
            if (per_pend) begin
                if ($urandom_range(0, 15) == 0) per_req = 1'b0;
            end else begin
                set_per(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), addr_of(int'($urandom_range(0, 31))), $urandom);
            end
            settle();

            n_checks++;
            if ({cpu_rvalid, cpu_rdata, per_rvalid, per_rdata} !==
                {ret_owner == 1, (ret_owner == 1) ? ret_data : 32'h0, ret_owner == 2, (ret_owner == 2) ? ret_data : 32'h0}) begin
                n_fail++;
                $display("FAIL rand_return_%0d: got crv=%b crd=%h prv=%b prd=%h want owner=%0d data=%h",
                         cyc, cpu_rvalid, cpu_rdata, per_rvalid, per_rdata, ret_owner, ret_data);
            end

            per_turn = per_req && (!cpu_req || denied >= MAX_WAIT);
            cpu_turn = cpu_req && !per_turn;
`ifdef DMEM_ARB_WPROT_EN
            blocked = per_turn && per_wren && (per_addr < PER_WR_BASE);
`else
            blocked = 1'b0;
`endif
            e_addr = per_turn ? per_addr : cpu_addr;
            e_wren = cpu_turn ? cpu_wren : (per_turn && per_wren && !blocked);
            e_data = cpu_turn ? cpu_wdata : ((per_turn && !blocked) ? per_wdata : 32'h0);

            n_checks++;
            if ({cpu_stall, per_gnt, wren, per_err, address_dmem, data} !==
                {cpu_req && !cpu_turn, per_turn, e_wren, blocked, e_addr, e_data}) begin
                n_fail++;
                $display("FAIL rand_issue_%0d: got stall=%b gnt=%b wren=%b err=%b addr=%h data=%h want %b/%b/%b/%b/%h/%h",
                         cyc, cpu_stall, per_gnt, wren, per_err, address_dmem, data,
                         cpu_req && !cpu_turn, per_turn, e_wren, blocked, e_addr, e_data);
            end

            ret_owner = 0;
            if (cpu_turn && !cpu_wren) ret_owner = 1;
            if (per_turn && !per_wren) ret_owner = 2;
            if (ret_owner != 0) ret_data = ref_mem[idx_of(e_addr)];
            if (e_wren) ref_mem[idx_of(e_addr)] = e_data;
            denied   = (per_req && !per_turn) ? ((denied < MAX_WAIT) ? denied + 1 : MAX_WAIT) : 0;
            per_pend = per_req && !per_turn;
            tick();
        end
        set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
        set_per(1'b0, 1'b0, 32'h0, 32'h0);
        settle();
        n_checks++;
        if ({cpu_rvalid, per_rvalid} !== {ret_owner == 1, ret_owner == 2}) begin
            n_fail++;
            $display("FAIL rand_final_return: got crv=%b prv=%b want owner=%0d", cpu_rvalid, per_rvalid, ret_owner);
        end
        tick();
    endtask

    initial begin
        reset = 1'b0;
        set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
        set_per(1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        test_reset();
        test_cpu_load();
        test_contention();
        test_alternating();
        test_abandon();
        test_reset_mid_read();
        test_wprot();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data-memory port between two requesters.
- Requester 0 is the processor's memory stage (lw/sw). Requester 1 is a peripheral master, e.g. a game/sprite engine reading and writing memory-mapped state.
- Sits between processor and dmem in the wrapper. Drives address_dmem/data/wren and stalls the processor when the CPU loses arbitration.
- CPU has priority. A bounded-wait counter guarantees peripheral progress.

Parameters:
- MAX_WAIT, 4: consecutive denied peripheral cycles before the peripheral is force-granted (range 1..15).
- PER_WR_BASE, 32'h0000_0800: lowest address the peripheral may write; used only with the optional feature.

Ports:
- clock  in  1  master clock, all state updates on rising edge
- reset  in  1  synchronous, active-low reset
- cpu_req  in  1  CPU access request this cycle
- cpu_wren  in  1  1=store, 0=load
- cpu_addr  in  32  CPU address
- cpu_wdata  in  32  CPU store data
- cpu_stall  out  1  CPU request not granted this cycle; hold request
- cpu_rvalid  out  1  cpu_rdata valid (cycle after granted CPU load)
- cpu_rdata  out  32  load data to CPU
- per_req  in  1  peripheral request; held until per_gnt
- per_wren  in  1  1=write, 0=read
- per_addr  in  32  peripheral address
- per_wdata  in  32  peripheral write data
- per_gnt  out  1  peripheral access issued this cycle
- per_rvalid  out  1  per_rdata valid (cycle after granted peripheral read)
- per_rdata  out  32  read data to peripheral
- per_err  out  1  protected-write violation pulse (optional feature; else tied 0)
- address_dmem  out  32  to dmem
- data  out  32  to dmem write data
- wren  out  1  to dmem write enable
- q_dmem  in  32  from dmem; one-cycle read latency

Behaviour:
- Grant (combinational from requests and registered wait_cnt):
  - cpu_gnt = cpu_req & ~(per_req & wait_cnt==MAX_WAIT).
  - per_gnt = per_req & (~cpu_req | wait_cnt==MAX_WAIT).
  - The two grants are mutually exclusive.
  - cpu_stall = cpu_req & ~cpu_gnt.
- Dmem mux:
  - cpu_gnt: address_dmem=cpu_addr, data=cpu_wdata, wren=cpu_wren.
  - per_gnt: the peripheral equivalents.
  - No grant: address_dmem=cpu_addr, data=0, wren=0.
- wait_cnt (4-bit):
  - Increments each cycle with per_req=1 and per_gnt=0, saturating at MAX_WAIT.
  - Clears on per_gnt or per_req=0.
- Forced grant lasts exactly one cycle; the next cycle reverts to CPU priority with wait_cnt=0.
- Read-return FSM, registered each cycle from the current grant. States:
  - RD_NONE: no read issued last cycle.
  - RD_CPU: granted CPU load last cycle.
  - RD_PER: granted peripheral read last cycle.
- Transitions: next = RD_CPU if cpu_gnt & ~cpu_wren; RD_PER if per_gnt & ~per_wren; else RD_NONE.
- Outputs by state:
  - RD_CPU: cpu_rvalid=1, cpu_rdata=q_dmem.
  - RD_PER: per_rvalid=1, per_rdata=q_dmem.
  - Non-valid rdata is 0.
- Back-to-back reads from alternating owners are legal; each return routes by the state for its cycle.
- Writes produce no rvalid.
- Peripheral dropping per_req before grant: the request is abandoned, wait_cnt clears, no access.
- Reset (reset==0 at clock edge):
  - State→RD_NONE, wait_cnt→0.
  - cpu_rvalid, per_rvalid, per_err = 0.
  - A read return pending at reset is discarded.
- While reset is low, grant outputs are forced 0: wren=0, per_gnt=0, cpu_stall=0, address_dmem=0, data=0.

Optional Feature:
- Macro DMEM_ARB_WPROT_EN.
- Defined: a granted peripheral write with per_addr < PER_WR_BASE is suppressed.
  - wren=0 and data=0.
  - per_gnt still asserts, so the request retires.
  - per_err pulses high for that same cycle.
  - Peripheral reads are unrestricted; the CPU is never restricted.
- Undefined: no address check; per_err is tied 0; PER_WR_BASE is unused.

Test Plan:
- CPU load only: cpu_req=1, cpu_wren=0, cpu_addr=0x10 with dmem[0x10]=0xDEADBEEF -> address_dmem=0x10, wren=0, cpu_stall=0; next cycle cpu_rvalid=1, cpu_rdata=0xDEADBEEF.
- Contention, MAX_WAIT=4: cpu_req and per_req held high from cycle 0 -> CPU granted cycles 0-3 (wait_cnt 0→4), cycle 4 per_gnt=1 and cpu_stall=1, cycle 5 CPU granted with wait_cnt=0.
- Alternating reads: cycle 0 per read 0x20 (data 0xA), forced; cycle 1 CPU read 0x30 (data 0xB) -> cycle 1 per_rvalid=1/per_rdata=0xA; cycle 2 cpu_rvalid=1/cpu_rdata=0xB; no cross-delivery.
- Abandon: per_req high 2 cycles under CPU traffic, then low -> wait_cnt returns 0, per_gnt never asserts, wren follows CPU only.
- Reset mid-read: CPU load granted, reset=0 at next edge -> cpu_rvalid=0 after the edge, wren=0, wait_cnt=0; after reset=1 a new request is granted normally.
- DMEM_ARB_WPROT_EN: per write addr 0x100 (below 0x800) -> per_gnt=1, per_err=1, wren=0; per write addr 0x900 -> wren=1, per_err=0.
